// File: rtl/digit_2_combiner_pkg.sv
// Shared constants for the two-digit combiner: digit display codes, FSM encoding and
// the tens*10+ones helper.
package digit_2_combiner_pkg;

  // Seven-segment display codes (gfedcba) for the digits 0..9
  localparam logic [7:0] N0 = 8'h3F;
  localparam logic [7:0] N1 = 8'h06;
  localparam logic [7:0] N2 = 8'h5B;
  localparam logic [7:0] N3 = 8'h4F;
  localparam logic [7:0] N4 = 8'h66;
  localparam logic [7:0] N5 = 8'h6D;
  localparam logic [7:0] N6 = 8'h7D;
  localparam logic [7:0] N7 = 8'h07;
  localparam logic [7:0] N8 = 8'h7F;
  localparam logic [7:0] N9 = 8'h6F;

  typedef enum logic [1:0] {
    StTen = 2'd0,
    StOne = 2'd1,
    StOut = 2'd2
  } state_e;

  // ten*10 + one as (ten<<3)+(ten<<1)+one; the result never exceeds 99
  function automatic logic [6:0] times_ten_plus(input logic [3:0] ten, input logic [3:0] one);
    return {ten, 3'b000} + {2'b00, ten, 1'b0} + {3'b000, one};
  endfunction

endpackage

// File: rtl/digit_2_combiner_if.sv
// Code-in / binary-out handshake bundle of the two-digit combiner.
// slave is the combiner's view, master the producer/consumer side.
interface digit_2_combiner_if;
  logic [7:0] i_code;
  logic       i_valid;
  logic       o_ready;
  logic       i_clear;
  logic [6:0] o_bin;
  logic       o_valid;
  logic       i_ready;
  logic       o_err;
  logic       o_busy;

  modport slave (
    input  i_code, i_valid, i_clear, i_ready,
    output o_ready, o_bin, o_valid, o_err, o_busy
  );

  modport master (
    output i_code, i_valid, i_clear, i_ready,
    input  o_ready, o_bin, o_valid, o_err, o_busy
  );
endinterface

// File: rtl/digit_code_decoder.sv
// Maps an 8-bit digit display code to its 4-bit value; hit is low for any other code.
module digit_code_decoder
  import digit_2_combiner_pkg::*;
(
  input  logic [7:0] code,
  output logic [3:0] digit,
  output logic       hit
);

  always_comb begin
    digit = 4'd0;
    hit   = 1'b1;
    case (code)
      N0:      digit = 4'd0;
      N1:      digit = 4'd1;
      N2:      digit = 4'd2;
      N3:      digit = 4'd3;
      N4:      digit = 4'd4;
      N5:      digit = 4'd5;
      N6:      digit = 4'd6;
      N7:      digit = 4'd7;
      N8:      digit = 4'd8;
      N9:      digit = 4'd9;
      default: hit   = 1'b0;
    endcase
  end

endmodule

// File: rtl/digit_2_combiner.sv
// Reassembles a tens-then-ones stream of digit display codes into a binary value 0..99.
// Define DIGIT_TIMEOUT_EN to abandon an entry whose ones digit is late.
module digit_2_combiner
  import digit_2_combiner_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned TO_W           = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  digit_2_combiner_if.slave  bus
);

  if ((2 ** TO_W) <= TIMEOUT_CYCLES) begin : g_bad_to_w
    $error("TO_W too narrow for TIMEOUT_CYCLES");
  end

  state_e     state_q, state_d;
  logic [3:0] ten_q, ten_d;
  logic [6:0] bin_q, bin_d;
  logic       err_q, err_d;

  logic [3:0] digit;
  logic       hit;
  logic       accept;
  logic       timeout;

  digit_code_decoder u_decoder (
    .code  (bus.i_code),
    .digit (digit),
    .hit   (hit)
  );

  assign accept = bus.i_valid & bus.o_ready;

`ifdef DIGIT_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Held at zero outside S_ONE so the count starts fresh on every entry
  always_comb begin
    to_cnt_d = to_cnt_q + TO_W'(1);
    if (state_q != StOne || accept || bus.i_clear) begin
      to_cnt_d = '0;
    end
  end

  assign timeout = (state_q == StOne) && !accept && !bus.i_clear &&
                   (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StTen;
      ten_q   <= 4'd0;
      bin_q   <= 7'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ten_q   <= ten_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ten_d   = ten_q;
    bin_d   = bin_q;
    err_d   = 1'b0;
    case (state_q)
      StTen: begin
        if (!bus.i_clear && accept) begin
          if (hit) begin
            ten_d   = digit;
            state_d = StOne;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StOne: begin
        if (bus.i_clear) begin
          state_d = StTen;
        end else if (accept) begin
          if (hit) begin
            bin_d   = times_ten_plus(ten_q, digit);
            state_d = StOut;
          end else begin
            err_d   = 1'b1;
            state_d = StTen;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StTen;
        end
      end
      StOut: begin
        // A finished result survives i_clear; only a transfer releases it
        if (bus.i_ready) begin
          state_d = StTen;
        end
      end
      default: state_d = StTen;
    endcase
  end

  always_comb begin
    bus.o_ready = (state_q != StOut);
    bus.o_busy  = (state_q == StOne);
    bus.o_valid = (state_q == StOut);
    bus.o_bin   = bin_q;
    bus.o_err   = err_q;
  end

endmodule

// File: tb/tb_digit_2_combiner.sv
// Directed bench for digit_2_combiner with a scoreboard of expected results.
module tb_digit_2_combiner;

`ifdef DIGIT_TIMEOUT_EN
  localparam int unsigned ToCycles = 8;
`else
  localparam int unsigned ToCycles = 1000;
`endif

  logic clk;
  logic rst;
  digit_2_combiner_if bus();

  digit_2_combiner #(
    .TIMEOUT_CYCLES (ToCycles),
    .TO_W           (10)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [7:0] code_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  int total   = 0;
  int bad     = 0;
  int err_cnt = 0;
  int out_cnt = 0;
  int exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Output monitor: every transfer pops one expected value
  always @(negedge clk) begin
    if (!rst && bus.o_err === 1'b1) err_cnt++;
    if (!rst && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
      out_cnt++;
      if (exp_q.size() == 0) chk("spurious_out", 32'(bus.o_bin), 32'hFFFF);
      else chk("sb_bin", 32'(bus.o_bin), 32'(exp_q.pop_front()));
    end
  end

  // Present a code and hold it until accepted; returns 1 time unit after the accept edge
  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    bus.i_code  = c;
    bus.i_valid = 1'b1;
    @(negedge clk);
    while (bus.o_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_stall", 32'(n), 0);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int e0;
  int o0;

  initial begin
    rst         = 1'b0;
    bus.i_code  = 8'h00;
    bus.i_valid = 1'b0;
    bus.i_clear = 1'b0;
    bus.i_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_ready", 32'(bus.o_ready), 1);
    chk("rst_bin", 32'(bus.o_bin), 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_err", 32'(bus.o_err), 0);
    step();

    // 4 then 2 -> 42, o_valid for exactly one cycle
    exp_q.push_back(42);
    send(code_tab[4]);
    chk("busy_after_ten", 32'(bus.o_busy), 1);
    send(code_tab[2]);
    chk("v42_valid", 32'(bus.o_valid), 1);
    chk("v42_bin", 32'(bus.o_bin), 42);
    chk("v42_ready_out", 32'(bus.o_ready), 0);
    step();
    chk("v42_valid_drop", 32'(bus.o_valid), 0);

    // Back-pressure: 99 held while i_ready low, input in S_OUT not consumed
    bus.i_ready = 1'b0;
    exp_q.push_back(99);
    send(code_tab[9]);
    send(code_tab[9]);
    bus.i_code  = code_tab[1];
    bus.i_valid = 1'b1;
    o0 = out_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.o_valid), 1);
      chk("bp_bin", 32'(bus.o_bin), 99);
      chk("bp_ready", 32'(bus.o_ready), 0);
      step();
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    step();
    chk("bp_one_xfer", 32'(out_cnt - o0), 1);
    chk("bp_back_ten", 32'(bus.o_valid), 0);
    chk("bp_not_consumed", 32'(bus.o_busy), 0);

    // Bad code in S_TEN
    e0 = err_cnt;
    send(8'h00);
    chk("bad_ten_err", 32'(bus.o_err), 1);
    chk("bad_ten_busy", 32'(bus.o_busy), 0);
    step();
    chk("bad_ten_err_drop", 32'(bus.o_err), 0);
    chk("bad_ten_count", 32'(err_cnt - e0), 1);

    // 3, bad, 0, 7 -> single error then 7
    e0 = err_cnt;
    exp_q.push_back(7);
    send(code_tab[3]);
    send(8'hA5);
    chk("bad_one_busy", 32'(bus.o_busy), 0);
    send(code_tab[0]);
    send(code_tab[7]);
    chk("v07_bin", 32'(bus.o_bin), 7);
    step();
    chk("bad_one_count", 32'(err_cnt - e0), 1);

    // i_clear in S_ONE beats a same-cycle code
    e0 = err_cnt;
    o0 = out_cnt;
    send(code_tab[5]);
    bus.i_clear = 1'b1;
    bus.i_code  = code_tab[1];
    bus.i_valid = 1'b1;
    step();
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
    chk("clr_busy", 32'(bus.o_busy), 0);
    chk("clr_valid", 32'(bus.o_valid), 0);
    step();
    chk("clr_no_err", 32'(err_cnt - e0), 0);
    chk("clr_no_out", 32'(out_cnt - o0), 0);
    exp_q.push_back(0);
    send(code_tab[0]);
    send(code_tab[0]);
    step();

    // i_clear in S_OUT is ignored
    bus.i_ready = 1'b0;
    exp_q.push_back(12);
    send(code_tab[1]);
    send(code_tab[2]);
    bus.i_clear = 1'b1;
    step();
    bus.i_clear = 1'b0;
    chk("clr_out_valid", 32'(bus.o_valid), 1);
    chk("clr_out_bin", 32'(bus.o_bin), 12);
    bus.i_ready = 1'b1;
    step();

    // Boundary pairs, back to back
    for (int p = 0; p < 3; p++) begin
      int t;
      int o;
      t = (p == 0) ? 9 : (p == 1) ? 0 : 5;
      o = (p == 0) ? 0 : (p == 1) ? 9 : 8;
      exp_q.push_back(t * 10 + o);
      send(code_tab[t]);
      send(code_tab[o]);
      step();
    end

    // Async reset mid-entry
    o0 = out_cnt;
    send(code_tab[8]);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.o_busy), 0);
    chk("arst_ready", 32'(bus.o_ready), 1);
    #2 rst = 1'b0;
    repeat (3) step();
    chk("arst_no_out", 32'(out_cnt - o0), 0);

`ifdef DIGIT_TIMEOUT_EN
    // Idle 8 cycles in S_ONE -> error and back to S_TEN
    e0 = err_cnt;
    send(code_tab[6]);
    repeat (7) step();
    chk("to_still_busy", 32'(bus.o_busy), 1);
    step();
    chk("to_err", 32'(bus.o_err), 1);
    chk("to_busy", 32'(bus.o_busy), 0);
    step();
    chk("to_count", 32'(err_cnt - e0), 1);

    // Ones digit on the final cycle wins over the timeout
    e0 = err_cnt;
    exp_q.push_back(61);
    send(code_tab[6]);
    repeat (7) step();
    send(code_tab[1]);
    chk("to_late_valid", 32'(bus.o_valid), 1);
    chk("to_late_bin", 32'(bus.o_bin), 61);
    step();
    chk("to_late_no_err", 32'(err_cnt - e0), 0);
`endif

    repeat (2) step();
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
